// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter: shares the single-port data RAM between the core data
// port (fixed priority) and a DMA requester with a starvation-forced slot.
// Revision: 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        cpu_wen,
  input  logic [3:0]  cpu_flag,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_en,
  input  logic        dma_req,
  input  logic        dma_wen,
  input  logic [3:0]  dma_flag,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [3:0]  mem_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    FORCE   = 1'b1
  } state_t;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_CPU  = 2'd1;
  localparam logic [1:0] RD_DMA  = 2'd2;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [1:0]        rd_owner;
  logic [31:0]       cpu_rdata_q;

  logic              sel_dma;
  logic              cpu_go;
  logic              gnt;

  // Grant decode depends only on requests and registered state, never on mem_rdata
  always_comb begin
    sel_dma = 1'b0;
    cpu_go  = 1'b0;
    gnt     = 1'b0;
    if (state == FORCE) begin
      sel_dma = 1'b1;
      gnt     = dma_req;
    end else if (cpu_cen) begin
      cpu_go  = 1'b1;
    end else if (dma_req) begin
      sel_dma = 1'b1;
      gnt     = 1'b1;
    end
    if (rst) begin
      cpu_go = 1'b0;
      gnt    = 1'b0;
    end
  end

  assign mem_cen    = cpu_go | gnt;
  assign mem_wen    = sel_dma ? dma_wen   : cpu_wen;
  assign mem_flag   = sel_dma ? dma_flag  : cpu_flag;
  assign mem_addr   = sel_dma ? dma_addr  : cpu_addr;
  assign mem_wdata  = sel_dma ? dma_wdata : cpu_wdata;
  assign dma_gnt    = gnt;
  assign cpu_en     = (state == CPU_OWN);
  assign dma_rvalid = (rd_owner == RD_DMA);
  assign dma_rdata  = mem_rdata;
  assign cpu_rdata  = (rd_owner == RD_CPU) ? mem_rdata : cpu_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CPU_OWN;
      starve_cnt  <= '0;
      rd_owner    <= RD_NONE;
      cpu_rdata_q <= '0;
    end else begin
      case (state)
        CPU_OWN: if (dma_req && !gnt && (starve_cnt == LIMIT_M1)) state <= FORCE;
        default: state <= CPU_OWN;
      endcase

      if (dma_req && !gnt) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (cpu_go && !cpu_wen)   rd_owner <= RD_CPU;
      else if (gnt && !dma_wen) rd_owner <= RD_DMA;
      else                      rd_owner <= RD_NONE;

      // Keeps the last core read visible through DMA slots and stalls
      if (rd_owner == RD_CPU) cpu_rdata_q <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter: scoreboard bench with a transaction-level arbitration
// model, a behavioural RAM, and randomized core/DMA traffic.
// Revision: 1.0
// ============================================================================
module tb_ram_port_arbiter;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cen, cpu_wen;
  logic [3:0]  cpu_flag;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_en;
  logic        dma_req, dma_wen;
  logic [3:0]  dma_flag;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_cen, mem_wen;
  logic [3:0]  mem_flag;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_flag(cpu_flag), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_en(cpu_en),
    .dma_req(dma_req), .dma_wen(dma_wen), .dma_flag(dma_flag), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_flag(mem_flag), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM, 64 words, registered read; garbage when not reading
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_cen && !mem_wen) begin
      mem_rdata <= ram[mem_addr[7:2]];
    end else begin
      mem_rdata <= $urandom;
      if (mem_cen) begin
        for (int b = 0; b < 4; b++)
          if (mem_flag[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  exp_t        mon_e;
  logic [31:0] exp_cpu_last;
  int          checks   = 0;
  int          failures = 0;

  // Reference model state
  logic [31:0] ref_mem [64];
  int          denied;
  bit          forced;
  bit          last_en;
  bit          dma_taken;
  bit          act_gnt, act_en;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: read returns and held core read data, sampled mid-cycle
  always @(negedge clk) begin
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      mon_e = cpu_q.pop_front();
      exp_cpu_last = mon_e.data;
    end
    check32("cpu_rdata", cpu_rdata, exp_cpu_last);
    if (dma_q.size() > 0 && dma_q[0].due == cyc) begin
      mon_e = dma_q.pop_front();
      check32("dma_rvalid_expected", 32'(dma_rvalid), 32'd1);
      if (dma_rvalid) check32("dma_rdata", dma_rdata, mon_e.data);
    end else begin
      check32("dma_rvalid_spurious", 32'(dma_rvalid), 32'd0);
    end
  end

  task automatic access(input logic wen, input logic [31:0] addr, input logic [3:0] flag,
                        input logic [31:0] wdata, input bit is_cpu);
    exp_t e;
    int   idx;
    idx = int'(addr[7:2]);
    if (wen) begin
      for (int b = 0; b < 4; b++)
        if (flag[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.due  = cyc + 1;
      e.data = ref_mem[idx];
      if (is_cpu) cpu_q.push_back(e);
      else        dma_q.push_back(e);
    end
  endtask

  // One cycle of the reference: who owns the RAM, and how starvation evolves
  task automatic model_step();
    int owner;
    bit en_exp;
    en_exp = !forced;
    if (forced)       owner = dma_req ? 2 : 0;
    else if (cpu_cen) owner = 1;
    else if (dma_req) owner = 2;
    else              owner = 0;
    act_gnt = dma_gnt;
    act_en  = cpu_en;
    check32("cpu_en", 32'(cpu_en), 32'(en_exp));
    check32("dma_gnt", 32'(dma_gnt), 32'(owner == 2));
    check32("mem_cen", 32'(mem_cen), 32'(owner != 0));
    if (owner == 1) begin
      check32("mem_addr_cpu", mem_addr, cpu_addr);
      check32("mem_wen_cpu", 32'(mem_wen), 32'(cpu_wen));
      check32("mem_flag_cpu", 32'(mem_flag), 32'(cpu_flag));
      if (cpu_wen) check32("mem_wdata_cpu", mem_wdata, cpu_wdata);
      access(cpu_wen, cpu_addr, cpu_flag, cpu_wdata, 1'b1);
    end else if (owner == 2) begin
      check32("mem_addr_dma", mem_addr, dma_addr);
      check32("mem_wen_dma", 32'(mem_wen), 32'(dma_wen));
      check32("mem_flag_dma", 32'(mem_flag), 32'(dma_flag));
      if (dma_wen) check32("mem_wdata_dma", mem_wdata, dma_wdata);
      access(dma_wen, dma_addr, dma_flag, dma_wdata, 1'b0);
      dma_taken = 1'b1;
    end
    if (forced) begin
      forced = 1'b0;
      denied = 0;
    end else if (dma_req && owner != 2) begin
      denied++;
      if (denied == STARVE_LIMIT) forced = 1'b1;
    end else begin
      denied = 0;
    end
    last_en = en_exp;
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic cen, input logic wen, input int idx, input logic [31:0] wd);
    cpu_cen   = cen;
    cpu_wen   = wen;
    cpu_flag  = 4'hF;
    cpu_addr  = 32'h4000_0000 | (32'(idx) << 2);
    cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic wen, input int idx, input logic [31:0] wd,
                         input logic [3:0] flag);
    dma_req   = req;
    dma_wen   = wen;
    dma_flag  = flag;
    dma_addr  = 32'h4000_0000 | (32'(idx) << 2);
    dma_wdata = wd;
  endtask

  // Asynchronous reset mid-cycle; pending returns are discarded
  task automatic do_reset();
    #1;
    rst = 1'b1;
    cpu_q.delete();
    dma_q.delete();
    exp_cpu_last = 32'h0;
    denied    = 0;
    forced    = 1'b0;
    last_en   = 1'b1;
    dma_taken = 1'b0;
    cpu_cen   = 1'b0;
    set_dma(1'b1, 1'b0, 3, 32'h0, 4'hF);
    #1;
    check32("reset_cpu_en", 32'(cpu_en), 32'd1);
    check32("reset_dma_gnt", 32'(dma_gnt), 32'd0);
    dma_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic core_gen(input int pct);
    if (last_en)
      set_cpu(($urandom_range(0, 99) < pct), 1'($urandom), $urandom_range(0, 63), $urandom);
    if (last_en && cpu_cen) cpu_flag = 4'($urandom);
  endtask

  task automatic dma_gen(input int pct);
    if (dma_taken) begin
      dma_req   = 1'b0;
      dma_taken = 1'b0;
    end
    if (!dma_req && $urandom_range(0, 99) < pct)
      set_dma(1'b1, 1'($urandom), $urandom_range(0, 63), $urandom, 4'($urandom));
  endtask

  initial begin
    bit gnt_hist [10];
    bit en_hist  [10];
    int first_gnt;
    int cpu_pct [4];
    int dma_pct [4];
    logic [31:0] w;

    cpu_pct = '{90, 50, 100, 20};
    dma_pct = '{50, 50, 80, 30};
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    set_dma(1'b0, 1'b0, 0, 32'h0, 4'h0);
    for (int i = 0; i < 64; i++) begin
      w = (i == 4)  ? 32'h1234_5678 :
          (i == 12) ? 32'hAAAA_0001 :
          (i == 13) ? 32'hBBBB_0002 : $urandom;
      ram[i]    <= w;
      ref_mem[i] = w;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Core read with no DMA
    set_cpu(1'b1, 1'b0, 4, 32'h0);
    tick();
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    tick();

    // DMA partial write while core idle, then core reads it back
    set_dma(1'b1, 1'b1, 8, 32'hCAFE_BABE, 4'b0011);
    tick();
    check32("dma_write_gnt", 32'(act_gnt), 32'd1);
    dma_req = 1'b0;
    set_cpu(1'b1, 1'b0, 8, 32'h0);
    tick();
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    tick();

    // Busy core starves a held DMA read until the forced slot
    first_gnt = -1;
    for (int k = 0; k < 10; k++) begin
      if (k < 7)       set_cpu(1'b1, 1'b1, 40 + k, $urandom);
      else if (k == 7) set_cpu(1'b1, 1'b0, 12, 32'h0);
      else if (k == 8) set_cpu(1'b1, 1'b0, 50, 32'h0);
      set_dma(k < 9, 1'b0, 13, 32'h0, 4'hF);
      tick();
      gnt_hist[k] = act_gnt;
      en_hist[k]  = act_en;
    end
    for (int k = 0; k < 10; k++)
      if (gnt_hist[k] && first_gnt < 0) first_gnt = k;
    check32("forced_slot_cycle", 32'(first_gnt), 32'(STARVE_LIMIT));
    check32("forced_slot_cpu_en", 32'(en_hist[8]), 32'd0);
    check32("core_resumes", 32'(en_hist[9]), 32'd1);
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    tick();

    // DMA request withdrawn during the forced slot
    for (int k = 0; k < 10; k++) begin
      if (k != 9) set_cpu(1'b1, 1'b1, 41 + k, $urandom);
      set_dma(k < 8, 1'b0, 20, 32'h0, 4'hF);
      tick();
    end
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    tick();

    // Reset right after a granted DMA read
    set_dma(1'b1, 1'b0, 13, 32'h0, 4'hF);
    tick();
    do_reset();

    // Randomized traffic, with a mid-operation reset between phases
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 600; n++) begin
        core_gen(cpu_pct[p]);
        dma_gen(dma_pct[p]);
        tick();
      end
      do_reset();
    end

    for (int n = 0; n < 20; n++) begin
      core_gen(40);
      dma_gen(40);
      tick();
    end
    cpu_cen = 1'b0;
    if (dma_taken) dma_req = 1'b0;
    tick();
    cpu_cen = 1'b0;
    dma_req = 1'b0;
    tick();
    tick();
    check32("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check32("dma_q_drained", 32'(dma_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
